pow2_mac_pe: RTL
================

# pow2_mac_pe

Parametrised weight-stationary processing element for the low-power CNN systolic array: a three-stage pipeline that multiplies an activation by a power-of-two weight (sign + shift code) and adds the upstream partial sum. Generalises the single-weight PE with a selectable multi-entry weight bank, configurable data and shift widths, freeze-on-stall pipeline behaviour, optional saturation, and per-beat last/overflow tagging. Instances chain horizontally (activation forward) and vertically (partial-sum cascade).

## Interface
- DW, 32, activation and partial-sum width (signed)
- SW, 3, shift-exponent width; weight code is SW+1 bits {sign, shift}
- NW, 4, weight bank depth (power of two, ≥2)
- CW, 5, beat-count width
- CLK in 1 clock, all logic on rising edge
- RSTN in 1 synchronous active-low reset, sampled on rising edge of CLK
- clk_ws_enable in 1 global advance; 0 freezes every register
- sat_en in 1 1 = saturate to DW signed range, 0 = wrap
- w_we in 1 weight bank write strobe
- w_addr in log2(NW) bank write address
- w_data in SW+1 weight code written
- in_valid in 1 activation beat present
- in_data in DW activation (signed)
- in_wsel in log2(NW) bank entry used for this beat
- in_count in CW remaining beats in row, including this one
- psum_in in DW upstream partial sum (signed)
- fwd_valid/fwd_data/fwd_count out 1/DW/CW activation forwarded to next PE (stage-0 register)
- fwd_last out 1 stage-0 beat is last (fwd_count == 0)
- out_valid/out_psum out 1/DW stage-2 result
- out_last out 1 stage-2 beat is last of row
- out_sat out 1 stage-2 result was clamped

## Operation
- Weight code: bit SW = sign, bits SW-1:0 = shift k; value = ±2^k. Code 0 = +1.
- Bank write: on edge with RSTN=1, clk_ws_enable=1, w_we=1, bank[w_addr] <= w_data. No effect on in-flight beats.
- Stage 0 (edge, enable=1): valid0 <= in_valid; if in_valid, capture in_data, bank[in_wsel] (read-before-write: same-edge write to that entry is not seen), count0 <= in_count − 1 (mod 2^CW). If in_valid=0, valid0 <= 0 and data/count regs clear to 0.
- Stage 1: prod = ±(sign-extended data << k), computed at DW+2^SW bits; valid1, prod, count1, last1 registered from stage 0. Bubble clears to 0.
- Stage 2: sum = prod + sign-extended psum_in at DW+2^SW+1 bits. sat_en=1: clamp to [−2^(DW−1), 2^(DW−1)−1], out_sat=1 when clamped. sat_en=0: low DW bits, out_sat=0. Bubble: out_psum=0, out_sat=0, out_last=0.
- psum_in is consumed only when valid1=1; otherwise ignored.
- Last flag: count0 == 0 (i.e. in_count == 1) marks last; carried through stages 1 and 2. in_count == 0 wraps to all-ones: not last, no error.
- clk_ws_enable=0: all pipeline regs and bank hold; w_we and in_valid ignored (beat dropped, upstream must hold).
- Reset (RSTN=0 on edge, regardless of enable): all outputs 0, all valids 0, bank entries 0; in-flight beats discarded.

## Timing
- Activation accepted on edge E0 → fwd_* valid after E0 (1-cycle forward latency).
- psum_in must be valid in the cycle between E1 and E2; sampled on E2.
- out_psum/out_valid/out_last/out_sat valid after E2: 3-cycle latency, throughput 1 beat/cycle.
- Each frozen cycle (enable=0) adds exactly 1 cycle to all latencies; no data lost in-pipeline.
- sat_en sampled on E2 (applies per beat at add stage).

## Test plan
- Reset/defaults: RSTN=0 two cycles with in_valid=1 → all outputs 0; release, send in_data=5, wsel=0 (bank reset=+1), psum_in=10 → out_psum=15 three cycles later.
- Shift/sign: bank[2]=4'b1011 (−8), in_data=3, psum_in=100 → out_psum=76; bank[1]=4'b0111, in_data=−2 → prod −256.
- Back-to-back row: in_count=4,3,2,1 consecutive beats → fwd_count 3,2,1,0, fwd_last only on 4th, out_last only on 4th output, no bubbles.
- Stall: enable=0 for 2 cycles mid-stream → outputs hold, results identical to unstalled run shifted by 2 cycles.
- Saturation: DW=32, bank=+128, in_data=0x7FFFFFFF, psum_in=1 → sat_en=1: 0x7FFFFFFF, out_sat=1; sat_en=0: low 32 bits of wide sum, out_sat=0; in_data=0x80000000 with −1 weight, sat_en=1 → 0x7FFFFFFF.
- Bank collision/reset mid-op: write bank[0] on same edge as beat using wsel=0 → old weight used; assert RSTN=0 with 3 beats in flight → no out_valid afterwards.

Source files
------------

// File: rtl/pow2_mac_pe.sv
// pow2_mac_pe: three-stage weight-stationary PE multiplying by a banked power-of-two weight and adding the upstream partial sum
module pow2_mac_pe #(
  parameter int DW = 32,
  parameter int SW = 3,
  parameter int NW = 4,
  parameter int CW = 5
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  clk_ws_enable,
  input  logic                  sat_en,
  input  logic                  w_we,
  input  logic [$clog2(NW)-1:0] w_addr,
  input  logic [SW:0]           w_data,
  input  logic                  in_valid,
  input  logic [DW-1:0]         in_data,
  input  logic [$clog2(NW)-1:0] in_wsel,
  input  logic [CW-1:0]         in_count,
  input  logic [DW-1:0]         psum_in,
  output logic                  fwd_valid,
  output logic [DW-1:0]         fwd_data,
  output logic [CW-1:0]         fwd_count,
  output logic                  fwd_last,
  output logic                  out_valid,
  output logic [DW-1:0]         out_psum,
  output logic                  out_last,
  output logic                  out_sat
);
  localparam int PW = DW + 2**SW;
  localparam int XW = PW + 1;
  logic [SW:0]   bank [NW];
  logic [SW:0]   w0;
  logic          valid1, last1;
  logic [PW-1:0] prod1;
  logic [PW-1:0] mag, prod;
  logic [XW-1:0] sum;
  logic          ovf;
  logic [DW-1:0] satv;
  assign fwd_last = fwd_valid && fwd_count == '0;
  assign mag  = PW'($signed(fwd_data)) << w0[SW-1:0];
  assign prod = w0[SW] ? -mag : mag;
  assign sum  = XW'($signed(prod1)) + XW'($signed(psum_in));
  // result fits DW signed bits only when the bits above the DW sign bit all match it
  assign ovf  = sum[XW-1:DW-1] != '0 && sum[XW-1:DW-1] != '1;
  assign satv = {sum[XW-1], {(DW-1){~sum[XW-1]}}};
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      for (int i = 0; i < NW; i++) bank[i] <= '0;
      fwd_valid <= 1'b0;
      fwd_data  <= '0;
      fwd_count <= '0;
      w0        <= '0;
      valid1    <= 1'b0;
      prod1     <= '0;
      last1     <= 1'b0;
      out_valid <= 1'b0;
      out_psum  <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (clk_ws_enable) begin
      if (w_we) bank[w_addr] <= w_data;
      fwd_valid <= in_valid;
      fwd_data  <= in_valid ? in_data : '0;
      fwd_count <= in_valid ? in_count - 1'b1 : '0;
      w0        <= in_valid ? bank[in_wsel] : '0;
      valid1    <= fwd_valid;
      prod1     <= fwd_valid ? prod : '0;
      last1     <= fwd_last;
      out_valid <= valid1;
      out_psum  <= !valid1 ? '0 : (sat_en && ovf) ? satv : sum[DW-1:0];
      out_last  <= valid1 && last1;
      out_sat   <= valid1 && sat_en && ovf;
    end
  end
endmodule
